// File: rtl/rtc_bus_sequencer.sv
// Two-phase (address then data) bus cycle sequencer for a multiplexed-AD RTC.
// All bus outputs, including the tri-state enable, are registered from the next-state decode.
module rtc_bus_sequencer #(
   parameter int DATA_W  = 8,
   parameter int T_SETUP = 2,
   parameter int T_PULSE = 4,
   parameter int T_HOLD  = 2,
   parameter int T_TURN  = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   inout  wire  [DATA_W-1:0] ad,
   output logic              ad_sel,
   output logic              cs_n,
   output logic              rd_n,
   output logic              wr_n
);

   localparam int MAX_SP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
   localparam int MAX_HT = (T_HOLD > T_TURN) ? T_HOLD : T_TURN;
   localparam int MAX_T  = (MAX_SP > MAX_HT) ? MAX_SP : MAX_HT;
   localparam int CNT_W  = $clog2(MAX_T) + 1;

   localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP);
   localparam logic [CNT_W-1:0] C_PULSE = CNT_W'(T_PULSE);
   localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(T_HOLD);
   localparam logic [CNT_W-1:0] C_TURN  = CNT_W'(T_TURN);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_A_SETUP  = 4'd1;
   localparam logic [3:0] S_A_STROBE = 4'd2;
   localparam logic [3:0] S_A_HOLD   = 4'd3;
   localparam logic [3:0] S_TURN     = 4'd4;
   localparam logic [3:0] S_D_SETUP  = 4'd5;
   localparam logic [3:0] S_D_STROBE = 4'd6;
   localparam logic [3:0] S_D_HOLD   = 4'd7;
   localparam logic [3:0] S_DONE     = 4'd8;

   logic [3:0]        state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic              last;
   logic              write_q, write_nx;
   logic [DATA_W-1:0] addr_q, addr_nx;
   logic [DATA_W-1:0] wdata_q, wdata_nx;
   logic [DATA_W-1:0] cap_q;
   logic              ad_oe;
   logic [DATA_W-1:0] ad_q;
   logic              cs_n_nx, rd_n_nx, wr_n_nx, sel_nx, oe_nx;
   logic [DATA_W-1:0] ad_nx;

   assign ad = ad_oe ? ad_q : 'z;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      last     = (cnt == CNT_W'(1));
      write_nx = write_q;
      addr_nx  = addr_q;
      wdata_nx = wdata_q;
      case (state)
         S_IDLE: if (req_valid) begin
            state_nx = S_A_SETUP;
            write_nx = req_write;
            addr_nx  = req_addr;
            wdata_nx = req_wdata;
         end
         S_A_SETUP:  if (last) state_nx = S_A_STROBE;
         S_A_STROBE: if (last) state_nx = S_A_HOLD;
         S_A_HOLD:   if (last) state_nx = write_q ? S_D_SETUP : S_TURN;
         S_TURN:     if (last) state_nx = S_D_SETUP;
         S_D_SETUP:  if (last) state_nx = S_D_STROBE;
         S_D_STROBE: if (last) state_nx = S_D_HOLD;
         S_D_HOLD:   if (last) state_nx = S_DONE;
         default:    state_nx = S_IDLE;
      endcase
      // Counter reloads on every state change and counts down to 1 within a timed state.
      if (state_nx != state) begin
         case (state_nx)
            S_A_SETUP, S_D_SETUP:   cnt_nx = C_SETUP;
            S_A_STROBE, S_D_STROBE: cnt_nx = C_PULSE;
            S_A_HOLD, S_D_HOLD:     cnt_nx = C_HOLD;
            S_TURN:                 cnt_nx = C_TURN;
            default:                cnt_nx = '0;
         endcase
      end else if (cnt != '0) begin
         cnt_nx = cnt - CNT_W'(1);
      end
   end

   always_comb begin
      cs_n_nx = 1'b1;
      rd_n_nx = 1'b1;
      wr_n_nx = 1'b1;
      sel_nx  = 1'b0;
      oe_nx   = 1'b0;
      ad_nx   = addr_nx;
      case (state_nx)
         S_A_SETUP, S_A_HOLD: oe_nx = 1'b1;
         S_A_STROBE: begin
            oe_nx   = 1'b1;
            cs_n_nx = 1'b0;
            wr_n_nx = 1'b0;
         end
         S_TURN: sel_nx = 1'b1;
         S_D_SETUP, S_D_HOLD: begin
            sel_nx = 1'b1;
            oe_nx  = write_nx;
            ad_nx  = wdata_nx;
         end
         S_D_STROBE: begin
            sel_nx  = 1'b1;
            oe_nx   = write_nx;
            ad_nx   = wdata_nx;
            cs_n_nx = 1'b0;
            if (write_nx) wr_n_nx = 1'b0;
            else          rd_n_nx = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cap_q     <= '0;
         rsp_rdata <= '0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
         req_ready <= 1'b1;
         cs_n      <= 1'b1;
         rd_n      <= 1'b1;
         wr_n      <= 1'b1;
         ad_sel    <= 1'b0;
         ad_oe     <= 1'b0;
         ad_q      <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         write_q   <= write_nx;
         addr_q    <= addr_nx;
         wdata_q   <= wdata_nx;
         // Sample the bus on the edge that ends the strobe, while rd_n is still low.
         if (state == S_D_STROBE && last && !write_q) cap_q <= ad;
         if (state_nx == S_DONE && !write_q) rsp_rdata <= cap_q;
         rsp_valid <= (state_nx == S_DONE);
         busy      <= (state_nx != S_IDLE);
         req_ready <= (state_nx == S_IDLE);
         cs_n      <= cs_n_nx;
         rd_n      <= rd_n_nx;
         wr_n      <= wr_n_nx;
         ad_sel    <= sel_nx;
         ad_oe     <= oe_nx;
         ad_q      <= ad_nx;
      end
   end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: default 8-bit instance plus a 16-bit all-ones-timing instance,
// each with an RTC model that drives the bus while rd_n is low.
module tb_rtc_bus_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   logic        rv0, rr0, rw0, rsv0, busy0, sel0, csn0, rdn0, wrn0;
   logic [7:0]  ra0, rdw0, rsd0, m_data0;
   wire  [7:0]  ad0;
   logic        rv1, rr1, rw1, rsv1, busy1, sel1, csn1, rdn1, wrn1;
   logic [15:0] ra1, rdw1, rsd1, m_data1;
   wire  [15:0] ad1;

   assign ad0 = (!rdn0 && !csn0) ? m_data0 : 'z;
   assign ad1 = (!rdn1 && !csn1) ? m_data1 : 'z;

   rtc_bus_sequencer u0 (
      .clk(clk), .reset_n(reset_n), .req_valid(rv0), .req_ready(rr0), .req_write(rw0),
      .req_addr(ra0), .req_wdata(rdw0), .rsp_valid(rsv0), .rsp_rdata(rsd0), .busy(busy0),
      .ad(ad0), .ad_sel(sel0), .cs_n(csn0), .rd_n(rdn0), .wr_n(wrn0)
   );

   rtc_bus_sequencer #(.DATA_W(16), .T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_TURN(1)) u1 (
      .clk(clk), .reset_n(reset_n), .req_valid(rv1), .req_ready(rr1), .req_write(rw1),
      .req_addr(ra1), .req_wdata(rdw1), .rsp_valid(rsv1), .rsp_rdata(rsd1), .busy(busy1),
      .ad(ad1), .ad_sel(sel1), .cs_n(csn1), .rd_n(rdn1), .wr_n(wrn1)
   );

   logic cont0 = 1'b0;
   logic cont1 = 1'b0;
   always @(negedge clk) begin
      if (!rdn0 && !csn0 && u0.ad_oe) cont0 <= 1'b1;
      if (!rdn1 && !csn1 && u1.ad_oe) cont1 <= 1'b1;
   end

   typedef struct {
      int          done_k;
      logic [15:0] rdata;
      logic        wr;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   logic [15:0] last_rd [2];

   logic        o_ready, o_busy, o_rv, o_oe, o_sel, o_cs, o_rdn, o_wrn;
   logic [15:0] o_rd, o_ad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int i, input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
      if (i == 0) begin
         rv0 = v; rw0 = w; ra0 = a[7:0]; rdw0 = d[7:0];
      end else begin
         rv1 = v; rw1 = w; ra1 = a; rdw1 = d;
      end
   endtask

   task automatic sample(input int i);
      if (i == 0) begin
         o_ready = rr0; o_busy = busy0; o_rv = rsv0; o_rd = {8'h00, rsd0}; o_ad = {8'h00, ad0};
         o_oe = u0.ad_oe; o_sel = sel0; o_cs = csn0; o_rdn = rdn0; o_wrn = wrn0;
      end else begin
         o_ready = rr1; o_busy = busy1; o_rv = rsv1; o_rd = rsd1; o_ad = ad1;
         o_oe = u1.ad_oe; o_sel = sel1; o_cs = csn1; o_rdn = rdn1; o_wrn = wrn1;
      end
   endtask

   task automatic chk_reset_outputs(input int i, input string tag);
      sample(i);
      chk({tag, "_cs_n"}, o_cs, 1);
      chk({tag, "_rd_n"}, o_rdn, 1);
      chk({tag, "_wr_n"}, o_wrn, 1);
      chk({tag, "_ad_oe"}, o_oe, 0);
      chk({tag, "_rsp_valid"}, o_rv, 0);
      chk({tag, "_rsp_rdata"}, o_rd, 0);
      chk({tag, "_busy"}, o_busy, 0);
   endtask

   // One bus transaction with a cycle-by-cycle expected waveform; optional held follow-on
   // request and optional asynchronous reset in cycle abort_k.
   task automatic run_txn(input int i, input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] md, input logic hold, input logic [15:0] na, input int abort_k);
      int s, p, h, tt, l, t, done, wait_c, dk;
      logic aph, dph, astb, dstb, exp_oe;
      exp_t e;
      s  = (i == 0) ? 2 : 1;
      p  = (i == 0) ? 4 : 1;
      h  = (i == 0) ? 2 : 1;
      tt = (i == 0) ? 2 : 1;
      l = s + p + h;
      t = w ? 0 : tt;
      done = 2 * l + t + 1;
      if (i == 0) m_data0 = md[7:0];
      else        m_data1 = md;
      drive(i, 1'b1, w, a, d);
      wait_c = 0;
      sample(i);
      while (!o_ready && wait_c < 200) begin
         @(negedge clk);
         sample(i);
         wait_c++;
      end
      chk("accept_wait_bound", (wait_c < 200), 1);
      e.done_k = done; e.rdata = md; e.wr = w;
      sb.push_back(e);
      @(negedge clk);
      if (hold) drive(i, 1'b1, 1'b0, na, 16'h0000);
      else      drive(i, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
      for (int k = 1; k <= done; k++) begin
         sample(i);
         aph  = (k <= l);
         astb = (k > s) && (k <= s + p);
         dk   = k - (l + t);
         dph  = (dk >= 1) && (dk <= l);
         dstb = dph && (dk > s) && (dk <= s + p);
         exp_oe = aph || (dph && w);
         if (k < done) begin
            chk("busy", o_busy, 1);
            chk("req_ready_busy", o_ready, 0);
            chk("ad_sel", o_sel, !aph);
            chk("ad_oe", o_oe, exp_oe);
            if (exp_oe) chk("ad_value", o_ad, aph ? a : d);
            chk("cs_n", o_cs, !(astb || dstb));
            chk("wr_n", o_wrn, !(astb || (dstb && w)));
            chk("rd_n", o_rdn, !(dstb && !w));
            chk("rsp_valid_early", o_rv, 0);
            chk("rsp_rdata_hold", o_rd, last_rd[i]);
         end else begin
            if (!w) last_rd[i] = md;
            chk("rsp_valid_done", o_rv, 1);
            chk("busy_done", o_busy, 1);
            chk("strobes_done", {o_cs, o_rdn, o_wrn}, 3'b111);
            chk("rsp_rdata_done", o_rd, last_rd[i]);
         end
         if (o_rv) begin
            if (sb.size() == 0) chk("scoreboard_underflow", 1, 0);
            else begin
               e = sb.pop_front();
               chk("rsp_latency", k, e.done_k);
               if (!e.wr) chk("sb_rdata", o_rd, e.rdata);
            end
         end
         if (k == abort_k) begin
            #1 reset_n = 1'b0;
            #1 chk_reset_outputs(i, "async_rst");
            sb.delete();
            last_rd[0] = '0;
            last_rd[1] = '0;
            drive(i, 1'b0, 1'b0, 16'h0000, 16'h0000);
            @(negedge clk);
            @(negedge clk);
            reset_n = 1'b1;
            for (int c = 0; c < done + 2; c++) begin
               @(negedge clk);
               sample(i);
               chk("abort_no_rsp", o_rv, 0);
            end
            chk("abort_ready", o_ready, 1);
            chk("abort_rdata", o_rd, 0);
            return;
         end
         @(negedge clk);
      end
      sample(i);
      chk("idle_ready", o_ready, 1);
      chk("idle_busy", o_busy, 0);
      chk("idle_rsp_valid", o_rv, 0);
      chk("idle_ad_oe", o_oe, 0);
      chk("sb_empty", sb.size(), 0);
   endtask

   initial begin
      last_rd[0] = '0;
      last_rd[1] = '0;
      m_data0 = '0;
      m_data1 = '0;
      reset_n = 1'b0;
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (3) begin
         @(negedge clk);
         drive(0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
         drive(1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
         #1;
         chk_reset_outputs(0, "reset0");
         chk_reset_outputs(1, "reset1");
      end
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      reset_n = 1'b1;
      @(negedge clk);
      sample(0);
      chk("post_reset_ready0", o_ready, 1);
      sample(1);
      chk("post_reset_ready1", o_ready, 1);

      run_txn(0, 1'b1, 16'h0021, 16'h0035, 16'h0000, 1'b0, 16'h0000, 0);
      run_txn(0, 1'b0, 16'h0022, 16'h0000, 16'h0059, 1'b1, 16'h0010, 0);
      run_txn(0, 1'b0, 16'h0010, 16'h0000, 16'h00A6, 1'b0, 16'h0000, 0);
      run_txn(0, 1'b1, 16'h0044, 16'h0077, 16'h0000, 1'b0, 16'h0000, 12);
      run_txn(0, 1'b1, 16'h0005, 16'h006C, 16'h0000, 1'b0, 16'h0000, 0);
      run_txn(0, 1'b0, 16'h0005, 16'h0000, 16'h003C, 1'b0, 16'h0000, 0);

      run_txn(1, 1'b1, 16'h0042, 16'hBEEF, 16'h0000, 1'b0, 16'h0000, 0);
      run_txn(1, 1'b0, 16'h0042, 16'h0000, 16'hBEEF, 1'b0, 16'h0000, 0);
      sample(1);
      chk("wide_rdata", o_rd, 16'hBEEF);

      chk("contention0", cont0, 0);
      chk("contention1", cont1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
